bsg_cache_nb_req_arbiter: RTL and testbench
===========================================

Name: bsg_cache_nb_req_arbiter

Overview:
Shares one non-blocking cache (bsg_cache_nb) between num_req_p requesters, such as several manycore link-to-cache adapters or a DMA/debug port. Request side: round-robin arbitration with grant locking. It prepends the requester index to each request id and routes out-of-order responses back by that index. A per-requester outstanding-request limit stops one requester from filling the cache's miss queue.

Parameters:
num_req_p, 2, number of requesters (>=1)
cache_addr_width_p, 28, cache packet address width
data_width_p, 32, data width; mask width = data_width_p/8
id_width_p, 17, requester-visible id width
max_out_p, 8, max in-flight requests per requester (>=1)
Derived: lg_req_lp = BSG_SAFE_CLOG2(num_req_p); cache_id_width_lp = id_width_p + lg_req_lp; req_pkt_w_lp / cache_pkt_w_lp = bsg_cache_nb_pkt_width with id_width_p / cache_id_width_lp

Ports:
clk_i  in  1  clock
reset_i  in  1  reset; asynchronous, active-high
req_pkt_i  in  num_req_p*req_pkt_w_lp  per-requester cache_nb packets (slot k = requester k)
req_v_i  in  num_req_p  request valid
req_yumi_o  out  num_req_p  request accepted (one-hot or zero)
req_data_o  out  data_width_p  response data, broadcast to all requesters
req_id_o  out  id_width_p  response id with the index bits stripped, broadcast
req_v_o  out  num_req_p  response valid, one-hot
req_yumi_i  in  num_req_p  response consumed
cache_pkt_o  out  cache_pkt_w_lp  packet to cache; src_id = {index, requester id}
v_o  out  1  packet valid
yumi_i  in  1  cache accepts packet
data_i  in  data_width_p  cache response data
id_i  in  cache_id_width_lp  cache response id
v_i  in  1  cache response valid
yumi_o  out  1  response consumed

Behaviour:
- State: rr_ptr_r [lg_req_lp], lock_r, lock_idx_r [lg_req_lp], out_cnt_r[k] [clog2(max_out_p+1)]. All of these clear to 0 asynchronously on reset_i.
- Outputs while reset_i=1: v_o=0, req_yumi_o=0, yumi_o=0, req_v_o=0.
- Eligibility: elig[k] = req_v_i[k] & (out_cnt_r[k] != max_out_p).
- Grant:
  - If lock_r=1, grant = lock_idx_r, regardless of elig.
  - Otherwise grant is the first eligible k scanning from rr_ptr_r upward, wrapping at num_req_p.
  - v_o = (lock_r | any elig) & ~reset_i.
- Address, data, mask and opcode of cache_pkt_o come from slot grant unchanged. src_id = {grant, slot src_id}. Zero added latency; the request path is fully combinational.
- Locking:
  - v_o=1 and yumi_i=0 sets lock_r=1 and lock_idx_r=grant, so the packet stays stable until yumi_i.
  - yumi_i=1 clears lock_r.
  - A locked requester has req_v_i held by protocol. Its lock is not broken by its counter saturating, because that cannot occur while it is pending.
- Acceptance: req_yumi_o[grant] = yumi_i. On yumi_i, rr_ptr_r <= grant+1 (wraps to 0 at num_req_p).
- Response routing:
  - ridx = id_i[cache_id_width_lp-1 -: lg_req_lp]; req_v_o[ridx] = v_i.
  - req_id_o = id_i[id_width_p-1:0]; yumi_o = v_i & req_yumi_i[ridx].
  - If num_req_p=1, ridx=0 and the index bit in src_id is 0.
  - ridx >= num_req_p is illegal: assert in simulation and drop (yumi_o=1).
- Counters:
  - out_cnt_r[k] increments on yumi_i with grant=k, and decrements on yumi_o with ridx=k.
  - Both in the same cycle leaves it unchanged. A request and a response for different k are independent.
  - Overflow and underflow are assertions.
- TAGST/TAGLA/AFL packets count like any other request, since the cache returns one response per request.
- Reset mid-operation clears locks and counters. Any cache responses still in flight after reset are the integrator's problem; the cache must be reset together with this block.

Decomposition:
- bsg_cache_nb_pkg: add a typedef macro declare_bsg_cache_nb_arb_id_s(id_width, lg_req) with fields {req_idx, req_id}, and a function to extract the index.
- Packet structs come from the existing declare_bsg_cache_nb_pkt_s macro, instantiated twice (requester id width and cache id width).
- Sub-module bsg_cache_nb_arb_out_ctr: a saturation-checked up/down counter with a full_o output, instantiated per requester.
- The round-robin scan stays inline.

Test Plan:
- Both requesters hold req_v_i=1 continuously and yumi_i=1 every cycle -> grants alternate 0,1,0,1; cache src_id MSB alternates; rr_ptr_r toggles.
- Requester 1 valid, yumi_i held 0 for 3 cycles while requester 0 asserts mid-stall -> grant stays 1 and cache_pkt_o stays stable; on yumi_i, req_yumi_o=2'b10, then requester 0 is granted next.
- max_out_p=2, requester 0 issues 2 requests with no responses -> third request blocked (v_o=0 if alone); returning one response with id MSB=0 re-enables it the following cycle.
- Cache returns out-of-order responses with id_i={1,id 0x5} then {0,id 0xA} -> req_v_o=2'b10 with req_id_o=0x5, then 2'b01 with 0xA. With req_yumi_i[1]=0, yumi_o=0 and the response is held.
- Same-cycle accept and response for requester 0 at out_cnt=1 -> count stays 1. Separately, assert reset_i asynchronously mid-lock -> all outputs 0 immediately, counters 0, and grant restarts at requester 0.
- num_req_p=1 build: traffic passes through, the index bit is 0, and the counter limit is enforced.

Source files
------------

// File: rtl/bsg_cache_nb_pkg.sv
// Shared types for the non-blocking cache and its request arbiter:
// opcode encoding, packet/id struct declaration macros, id helpers.

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

`ifndef BSG_CACHE_NB_PKT_WIDTH
`define BSG_CACHE_NB_PKT_WIDTH(addr_width_mp, data_width_mp, id_width_mp) \
  (6 + (addr_width_mp) + (data_width_mp) + ((data_width_mp) >> 3) + (id_width_mp))
`endif

// Packet layout, MSB first: opcode, addr, data, mask, src_id.
`ifndef DECLARE_BSG_CACHE_NB_PKT_S
`define DECLARE_BSG_CACHE_NB_PKT_S(addr_width_mp, data_width_mp, id_width_mp, struct_name_mp) \
  typedef struct packed { \
    bsg_cache_nb_opcode_e                opcode; \
    logic [(addr_width_mp)-1:0]          addr; \
    logic [(data_width_mp)-1:0]          data; \
    logic [((data_width_mp) >> 3)-1:0]   mask; \
    logic [(id_width_mp)-1:0]            src_id; \
  } struct_name_mp
`endif

// Cache-side id: requester index sits directly above the requester id.
`ifndef DECLARE_BSG_CACHE_NB_ARB_ID_S
`define DECLARE_BSG_CACHE_NB_ARB_ID_S(id_width_mp, lg_req_mp) \
  typedef struct packed { \
    logic [(lg_req_mp)-1:0]  req_idx; \
    logic [(id_width_mp)-1:0] req_id; \
  } bsg_cache_nb_arb_id_s
`endif

package bsg_cache_nb_pkg;

  typedef enum logic [5:0] {
    e_cache_nb_lb     = 6'h00,
    e_cache_nb_lh     = 6'h01,
    e_cache_nb_lw     = 6'h02,
    e_cache_nb_ld     = 6'h03,
    e_cache_nb_sb     = 6'h08,
    e_cache_nb_sh     = 6'h09,
    e_cache_nb_sw     = 6'h0A,
    e_cache_nb_sd     = 6'h0B,
    e_cache_nb_tagst  = 6'h10,
    e_cache_nb_tagfl  = 6'h11,
    e_cache_nb_afl    = 6'h12,
    e_cache_nb_aflinv = 6'h13,
    e_cache_nb_ainv   = 6'h14,
    e_cache_nb_tagla  = 6'h15
  } bsg_cache_nb_opcode_e;

  // Requester index of a cache-side id: everything above the requester id.
  function automatic logic [31:0] bsg_cache_nb_arb_id_idx(input logic [63:0] id,
                                                          input int unsigned id_width);
    return 32'(id >> id_width);
  endfunction

endpackage

// File: rtl/bsg_cache_nb_arb_out_ctr.sv
// Per-requester in-flight request counter. Counts up on acceptance,
// down on response; simultaneous up and down cancel. full_o marks the limit.

module bsg_cache_nb_arb_out_ctr #(
  parameter int max_p = 8,
  localparam int w_lp = $clog2(max_p + 1)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic up_i,
  input  logic down_i,
  output logic full_o
);

  logic [w_lp-1:0] cnt_q, cnt_d;

  assign full_o = (cnt_q == w_lp'(max_p));

  // Next count: net change of +1, -1 or 0.
  always_comb begin
    cnt_d = cnt_q;
    if (up_i && !down_i)      cnt_d = cnt_q + w_lp'(1);
    else if (down_i && !up_i) cnt_d = cnt_q - w_lp'(1);
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // Overflow / underflow are protocol violations upstream.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(up_i && !down_i && full_o));
      assert (!(down_i && !up_i && (cnt_q == '0)));
    end
  end

endmodule

// File: rtl/bsg_cache_nb_req_arbiter.sv
// Shares one non-blocking cache among num_req_p requesters. Round-robin
// grant with locking while the cache stalls, requester index prepended to
// the id, responses steered back by that index, per-requester in-flight cap.
//
// Handshakes: a packet is offered with v_o and transferred in the cycle the
// consumer raises yumi_i (yumi may only be asserted while valid is high);
// once offered, the packet is held unchanged until transferred. The same
// valid/yumi rule applies to req_v_i/req_yumi_o, v_i/yumi_o and
// req_v_o/req_yumi_i.

module bsg_cache_nb_req_arbiter
  import bsg_cache_nb_pkg::*;
#(
  parameter int num_req_p          = 2,
  parameter int cache_addr_width_p = 28,
  parameter int data_width_p       = 32,
  parameter int id_width_p         = 17,
  parameter int max_out_p          = 8,
  localparam int lg_req_lp         = `BSG_SAFE_CLOG2(num_req_p),
  localparam int cache_id_width_lp = id_width_p + lg_req_lp,
  localparam int req_pkt_w_lp      = `BSG_CACHE_NB_PKT_WIDTH(cache_addr_width_p, data_width_p, id_width_p),
  localparam int cache_pkt_w_lp    = `BSG_CACHE_NB_PKT_WIDTH(cache_addr_width_p, data_width_p, cache_id_width_lp)
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_req_p*req_pkt_w_lp-1:0]   req_pkt_i,
  input  logic [num_req_p-1:0]                req_v_i,
  output logic [num_req_p-1:0]                req_yumi_o,
  output logic [data_width_p-1:0]             req_data_o,
  output logic [id_width_p-1:0]               req_id_o,
  output logic [num_req_p-1:0]                req_v_o,
  input  logic [num_req_p-1:0]                req_yumi_i,
  output logic [cache_pkt_w_lp-1:0]           cache_pkt_o,
  output logic                                v_o,
  input  logic                                yumi_i,
  input  logic [data_width_p-1:0]             data_i,
  input  logic [cache_id_width_lp-1:0]        id_i,
  input  logic                                v_i,
  output logic                                yumi_o
);

  `DECLARE_BSG_CACHE_NB_PKT_S(cache_addr_width_p, data_width_p, id_width_p, bsg_cache_nb_req_pkt_s);
  `DECLARE_BSG_CACHE_NB_PKT_S(cache_addr_width_p, data_width_p, cache_id_width_lp, bsg_cache_nb_cache_pkt_s);
  `DECLARE_BSG_CACHE_NB_ARB_ID_S(id_width_p, lg_req_lp);

  // Index-addressable vectors are padded to a power of two so that an
  // lg_req_lp-bit index always selects within range.
  localparam int pad_lp = 1 << lg_req_lp;

  bsg_cache_nb_req_pkt_s [num_req_p-1:0] req_pkt;
  bsg_cache_nb_req_pkt_s                 gnt_pkt;
  bsg_cache_nb_cache_pkt_s               cache_pkt;
  bsg_cache_nb_arb_id_s                  src_id;

  logic [lg_req_lp-1:0] rr_ptr_q, rr_ptr_d;
  logic                 lock_q, lock_d;
  logic [lg_req_lp-1:0] lock_idx_q, lock_idx_d;

  logic [num_req_p-1:0] full;
  logic [pad_lp-1:0]    elig;
  logic [pad_lp-1:0]    gnt_yumi;
  logic [pad_lp-1:0]    rsp_v;
  logic [pad_lp-1:0]    rsp_yumi;
  logic [lg_req_lp:0]   scan_idx;
  logic [lg_req_lp-1:0] grant;
  logic                 found;
  logic                 accept;
  logic [lg_req_lp-1:0] ridx;
  logic                 ridx_legal;
  logic                 rsp_done;

  assign req_pkt = req_pkt_i;

  // Round-robin scan from rr_ptr_q; a held lock overrides the scan.
  always_comb begin
    elig                  = '0;
    elig[num_req_p-1:0]   = req_v_i & ~full;
    grant                 = '0;
    found                 = 1'b0;
    scan_idx              = '0;
    for (int i = 0; i < num_req_p; i++) begin
      scan_idx = {1'b0, rr_ptr_q} + (lg_req_lp+1)'(i);
      if (scan_idx >= (lg_req_lp+1)'(num_req_p)) scan_idx = scan_idx - (lg_req_lp+1)'(num_req_p);
      if (!found && elig[scan_idx[lg_req_lp-1:0]]) begin
        found = 1'b1;
        grant = scan_idx[lg_req_lp-1:0];
      end
    end
    if (lock_q) grant = lock_idx_q;
  end

  assign v_o    = (lock_q | found) & ~reset_i;
  assign accept = v_o & yumi_i;

  // Forward the granted packet, tagging its id with the requester index.
  always_comb begin
    gnt_pkt          = req_pkt[grant];
    src_id.req_idx   = grant;
    src_id.req_id    = gnt_pkt.src_id;
    cache_pkt.opcode = gnt_pkt.opcode;
    cache_pkt.addr   = gnt_pkt.addr;
    cache_pkt.data   = gnt_pkt.data;
    cache_pkt.mask   = gnt_pkt.mask;
    cache_pkt.src_id = src_id;
    gnt_yumi         = '0;
    if (accept) gnt_yumi[grant] = 1'b1;
  end

  assign cache_pkt_o = cache_pkt;
  assign req_yumi_o  = gnt_yumi[num_req_p-1:0];

  // Lock on a stalled offer; advance the pointer past each accepted requester.
  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    if (accept) begin
      lock_d   = 1'b0;
      rr_ptr_d = (grant == lg_req_lp'(num_req_p - 1)) ? '0 : grant + lg_req_lp'(1);
    end else if (v_o) begin
      lock_d     = 1'b1;
      lock_idx_d = grant;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Response steering by the index field of the returned id.
  assign ridx       = lg_req_lp'(bsg_cache_nb_arb_id_idx(64'(id_i), id_width_p));
  assign ridx_legal = ({1'b0, ridx} < (lg_req_lp+1)'(num_req_p));
  assign req_data_o = data_i;
  assign req_id_o   = id_i[id_width_p-1:0];

  // One-hot response valid; an out-of-range index is swallowed.
  always_comb begin
    rsp_v                    = '0;
    rsp_yumi                 = '0;
    rsp_yumi[num_req_p-1:0]  = req_yumi_i;
    if (v_i && !reset_i && ridx_legal) rsp_v[ridx] = 1'b1;
    yumi_o = v_i & ~reset_i & (ridx_legal ? rsp_yumi[ridx] : 1'b1);
  end

  assign req_v_o  = rsp_v[num_req_p-1:0];
  assign rsp_done = yumi_o & ridx_legal;

  // An index the cache never received from us means a corrupted id.
  always_ff @(posedge clk_i) begin
    if (!reset_i && v_i) assert (ridx_legal);
  end

  for (genvar k = 0; k < num_req_p; k++) begin : g_ctr
    bsg_cache_nb_arb_out_ctr #(.max_p(max_out_p)) ctr (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .up_i    (accept && (grant == lg_req_lp'(k))),
      .down_i  (rsp_done && (ridx == lg_req_lp'(k))),
      .full_o  (full[k])
    );
  end

endmodule

// File: tb/tb_bsg_cache_nb_req_arbiter.sv
// Directed bench: two-requester arbiter with a limit of 2 in flight, plus a
// single-requester build.

module tb_bsg_cache_nb_req_arbiter;

  localparam int aw = 28;
  localparam int dw = 32;
  localparam int iw = 17;
  localparam int pw = 6 + aw + dw + dw/8 + iw;
  localparam int cw = pw + 1;

  logic            clk = 1'b0;
  logic            reset_i;

  logic [2*pw-1:0] req_pkt_i;
  logic [1:0]      req_v_i, req_yumi_o, req_v_o, req_yumi_i;
  logic [dw-1:0]   req_data_o, data_i;
  logic [iw-1:0]   req_id_o;
  logic [cw-1:0]   cache_pkt_o;
  logic            v_o, yumi_i, v_i, yumi_o;
  logic [iw:0]     id_i;

  logic [pw-1:0]   s_req_pkt_i;
  logic [0:0]      s_req_v_i, s_req_yumi_o, s_req_v_o, s_req_yumi_i;
  logic [dw-1:0]   s_req_data_o, s_data_i;
  logic [iw-1:0]   s_req_id_o;
  logic [cw-1:0]   s_cache_pkt_o;
  logic            s_v_o, s_yumi_i, s_v_i, s_yumi_o;
  logic [iw:0]     s_id_i;

  int n_checks = 0;
  int n_pass   = 0;

  logic [pw-1:0] pkt0, pkt1, spkt;
  logic [cw-1:0] e0, e1, es;

  always #5 clk = ~clk;

  bsg_cache_nb_req_arbiter #(.num_req_p(2), .max_out_p(2)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_pkt_i(req_pkt_i), .req_v_i(req_v_i), .req_yumi_o(req_yumi_o),
    .req_data_o(req_data_o), .req_id_o(req_id_o), .req_v_o(req_v_o), .req_yumi_i(req_yumi_i),
    .cache_pkt_o(cache_pkt_o), .v_o(v_o), .yumi_i(yumi_i),
    .data_i(data_i), .id_i(id_i), .v_i(v_i), .yumi_o(yumi_o)
  );

  bsg_cache_nb_req_arbiter #(.num_req_p(1), .max_out_p(2)) dut1 (
    .clk_i(clk), .reset_i(reset_i),
    .req_pkt_i(s_req_pkt_i), .req_v_i(s_req_v_i), .req_yumi_o(s_req_yumi_o),
    .req_data_o(s_req_data_o), .req_id_o(s_req_id_o), .req_v_o(s_req_v_o), .req_yumi_i(s_req_yumi_i),
    .cache_pkt_o(s_cache_pkt_o), .v_o(s_v_o), .yumi_i(s_yumi_i),
    .data_i(s_data_i), .id_i(s_id_i), .v_i(s_v_i), .yumi_o(s_yumi_o)
  );

  function automatic logic [pw-1:0] make_pkt(input logic [5:0] op, input logic [aw-1:0] a,
                                             input logic [dw-1:0] d, input logic [3:0] m,
                                             input logic [iw-1:0] id);
    return {op, a, d, m, id};
  endfunction

  function automatic logic [cw-1:0] make_cpkt(input logic [5:0] op, input logic [aw-1:0] a,
                                              input logic [dw-1:0] d, input logic [3:0] m,
                                              input logic idx, input logic [iw-1:0] id);
    return {op, a, d, m, idx, id};
  endfunction

  task automatic test_reset;
    reset_i = 1'b1; req_v_i = 2'b11; yumi_i = 1'b1; v_i = 1'b1; id_i = {1'b1, 17'h5};
    req_yumi_i = 2'b11; data_i = '0;
    @(negedge clk); #1;
    n_checks++; if (v_o !== 1'b0) $display("FAIL reset_v_o got %0b want 0", v_o); else n_pass++;
    n_checks++; if (req_yumi_o !== 2'b00) $display("FAIL reset_req_yumi_o got %b want 00", req_yumi_o); else n_pass++;
    n_checks++; if (yumi_o !== 1'b0) $display("FAIL reset_yumi_o got %0b want 0", yumi_o); else n_pass++;
    n_checks++; if (req_v_o !== 2'b00) $display("FAIL reset_req_v_o got %b want 00", req_v_o); else n_pass++;
    n_checks++; if (s_v_o !== 1'b0) $display("FAIL reset_single_v_o got %0b want 0", s_v_o); else n_pass++;
    @(negedge clk);
    reset_i = 1'b0; req_v_i = '0; yumi_i = 1'b0; v_i = 1'b0; id_i = '0; req_yumi_i = '0;
  endtask

  task automatic test_round_robin;
    @(negedge clk); req_v_i = 2'b11; yumi_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (req_yumi_o !== ((c % 2 == 1) ? 2'b10 : 2'b01))
        $display("FAIL rr_req_yumi_o[%0d] got %b want %b", c, req_yumi_o, (c % 2 == 1) ? 2'b10 : 2'b01);
      else n_pass++;
      n_checks++;
      if (cache_pkt_o !== ((c % 2 == 1) ? e1 : e0))
        $display("FAIL rr_cache_pkt[%0d] got %h want %h", c, cache_pkt_o, (c % 2 == 1) ? e1 : e0);
      else n_pass++;
      @(negedge clk);
    end
    #1;
    n_checks++; if (v_o !== 1'b0) $display("FAIL rr_both_full_v_o got %0b want 0", v_o); else n_pass++;
    n_checks++; if (req_yumi_o !== 2'b00) $display("FAIL rr_both_full_req_yumi got %b want 00", req_yumi_o); else n_pass++;
    req_v_i = '0; yumi_i = 1'b0;
  endtask

  task automatic test_limit_block;
    @(negedge clk); req_v_i = 2'b01; yumi_i = 1'b1; #1;
    n_checks++; if (v_o !== 1'b0) $display("FAIL limit_v_o got %0b want 0", v_o); else n_pass++;
    n_checks++; if (req_yumi_o !== 2'b00) $display("FAIL limit_req_yumi got %b want 00", req_yumi_o); else n_pass++;
    req_v_i = '0; yumi_i = 1'b0;
  endtask

  task automatic test_response_routing;
    @(negedge clk); v_i = 1'b1; id_i = {1'b1, 17'h5}; data_i = 32'h1234_0005; req_yumi_i = 2'b00; #1;
    n_checks++; if (req_v_o !== 2'b10) $display("FAIL rsp1_req_v_o got %b want 10", req_v_o); else n_pass++;
    n_checks++; if (req_id_o !== 17'h5) $display("FAIL rsp1_req_id got %h want 5", req_id_o); else n_pass++;
    n_checks++; if (req_data_o !== 32'h1234_0005) $display("FAIL rsp1_data got %h want 12340005", req_data_o); else n_pass++;
    n_checks++; if (yumi_o !== 1'b0) $display("FAIL rsp1_not_consumed_yumi got %0b want 0", yumi_o); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (req_v_o !== 2'b10) $display("FAIL rsp1_held_req_v_o got %b want 10", req_v_o); else n_pass++;
    req_yumi_i = 2'b10; #1;
    n_checks++; if (yumi_o !== 1'b1) $display("FAIL rsp1_yumi got %0b want 1", yumi_o); else n_pass++;
    @(negedge clk); id_i = {1'b0, 17'hA}; data_i = 32'h1234_000A; req_yumi_i = 2'b01;
    req_v_i = 2'b01; yumi_i = 1'b0; #1;
    n_checks++; if (req_v_o !== 2'b01) $display("FAIL rsp0_req_v_o got %b want 01", req_v_o); else n_pass++;
    n_checks++; if (req_id_o !== 17'hA) $display("FAIL rsp0_req_id got %h want a", req_id_o); else n_pass++;
    n_checks++; if (yumi_o !== 1'b1) $display("FAIL rsp0_yumi got %0b want 1", yumi_o); else n_pass++;
    n_checks++; if (v_o !== 1'b0) $display("FAIL rsp0_still_full_v_o got %0b want 0", v_o); else n_pass++;
    @(negedge clk); v_i = 1'b0; req_yumi_i = '0; yumi_i = 1'b1; #1;
    n_checks++; if (v_o !== 1'b1) $display("FAIL reenable_v_o got %0b want 1", v_o); else n_pass++;
    n_checks++; if (req_yumi_o !== 2'b01) $display("FAIL reenable_req_yumi got %b want 01", req_yumi_o); else n_pass++;
    n_checks++; if (cache_pkt_o !== e0) $display("FAIL reenable_pkt got %h want %h", cache_pkt_o, e0); else n_pass++;
    @(negedge clk); req_v_i = '0; yumi_i = 1'b0;
  endtask

  task automatic test_drain;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk); v_i = 1'b1; id_i = {(r == 2), 17'h30}; req_yumi_i = 2'b11; #1;
      n_checks++; if (yumi_o !== 1'b1) $display("FAIL drain_yumi[%0d] got %0b want 1", r, yumi_o); else n_pass++;
      n_checks++;
      if (req_v_o !== ((r == 2) ? 2'b10 : 2'b01))
        $display("FAIL drain_req_v_o[%0d] got %b want %b", r, req_v_o, (r == 2) ? 2'b10 : 2'b01);
      else n_pass++;
    end
    @(negedge clk); v_i = 1'b0; req_yumi_i = '0;
    req_v_i = 2'b10; yumi_i = 1'b1; #1;
    n_checks++; if (req_yumi_o !== 2'b10) $display("FAIL realign_req_yumi got %b want 10", req_yumi_o); else n_pass++;
    @(negedge clk); req_v_i = '0; yumi_i = 1'b0; v_i = 1'b1; id_i = {1'b1, 17'h41}; req_yumi_i = 2'b10; #1;
    n_checks++; if (yumi_o !== 1'b1) $display("FAIL realign_rsp_yumi got %0b want 1", yumi_o); else n_pass++;
    @(negedge clk); v_i = 1'b0; req_yumi_i = '0;
  endtask

  task automatic test_lock;
    @(negedge clk); req_v_i = 2'b10; yumi_i = 1'b0; #1;
    n_checks++; if (v_o !== 1'b1) $display("FAIL lock_v_o got %0b want 1", v_o); else n_pass++;
    n_checks++; if (cache_pkt_o !== e1) $display("FAIL lock_stall1_pkt got %h want %h", cache_pkt_o, e1); else n_pass++;
    @(negedge clk); req_v_i = 2'b11; #1;
    n_checks++; if (cache_pkt_o !== e1) $display("FAIL lock_stall2_pkt got %h want %h", cache_pkt_o, e1); else n_pass++;
    n_checks++; if (req_yumi_o !== 2'b00) $display("FAIL lock_stall2_req_yumi got %b want 00", req_yumi_o); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (cache_pkt_o !== e1) $display("FAIL lock_stall3_pkt got %h want %h", cache_pkt_o, e1); else n_pass++;
    @(negedge clk); yumi_i = 1'b1; #1;
    n_checks++; if (req_yumi_o !== 2'b10) $display("FAIL lock_release_req_yumi got %b want 10", req_yumi_o); else n_pass++;
    n_checks++; if (cache_pkt_o !== e1) $display("FAIL lock_release_pkt got %h want %h", cache_pkt_o, e1); else n_pass++;
    @(negedge clk); req_v_i = 2'b01; #1;
    n_checks++; if (req_yumi_o !== 2'b01) $display("FAIL lock_next_req_yumi got %b want 01", req_yumi_o); else n_pass++;
    n_checks++; if (cache_pkt_o !== e0) $display("FAIL lock_next_pkt got %h want %h", cache_pkt_o, e0); else n_pass++;
    @(negedge clk); req_v_i = '0; yumi_i = 1'b0;
  endtask

  task automatic test_same_cycle;
    @(negedge clk); req_v_i = 2'b01; yumi_i = 1'b1; v_i = 1'b1; id_i = {1'b0, 17'h50}; req_yumi_i = 2'b01; #1;
    n_checks++; if (req_yumi_o !== 2'b01) $display("FAIL same_req_yumi got %b want 01", req_yumi_o); else n_pass++;
    n_checks++; if (yumi_o !== 1'b1) $display("FAIL same_yumi_o got %0b want 1", yumi_o); else n_pass++;
    @(negedge clk); v_i = 1'b0; req_yumi_i = '0; #1;
    n_checks++; if (req_yumi_o !== 2'b01) $display("FAIL same_count1_req_yumi got %b want 01", req_yumi_o); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (v_o !== 1'b0) $display("FAIL same_count2_v_o got %0b want 0", v_o); else n_pass++;
    req_v_i = '0; yumi_i = 1'b0;
  endtask

  task automatic test_async_reset;
    @(negedge clk); req_v_i = 2'b10; yumi_i = 1'b0; #1;
    n_checks++; if (cache_pkt_o !== e1) $display("FAIL ar_pre_pkt got %h want %h", cache_pkt_o, e1); else n_pass++;
    @(negedge clk); req_v_i = 2'b11; #1;
    n_checks++; if (cache_pkt_o !== e1) $display("FAIL ar_locked_pkt got %h want %h", cache_pkt_o, e1); else n_pass++;
    #2; reset_i = 1'b1; yumi_i = 1'b1; v_i = 1'b1; id_i = {1'b0, 17'h1}; req_yumi_i = 2'b11; #1;
    n_checks++; if (v_o !== 1'b0) $display("FAIL ar_v_o got %0b want 0", v_o); else n_pass++;
    n_checks++; if (req_yumi_o !== 2'b00) $display("FAIL ar_req_yumi got %b want 00", req_yumi_o); else n_pass++;
    n_checks++; if (yumi_o !== 1'b0) $display("FAIL ar_yumi_o got %0b want 0", yumi_o); else n_pass++;
    n_checks++; if (req_v_o !== 2'b00) $display("FAIL ar_req_v_o got %b want 00", req_v_o); else n_pass++;
    @(negedge clk); reset_i = 1'b0; v_i = 1'b0; req_yumi_i = '0; req_v_i = 2'b11; yumi_i = 1'b1; #1;
    n_checks++; if (req_yumi_o !== 2'b01) $display("FAIL ar_restart_req_yumi got %b want 01", req_yumi_o); else n_pass++;
    n_checks++; if (cache_pkt_o !== e0) $display("FAIL ar_restart_pkt got %h want %h", cache_pkt_o, e0); else n_pass++;
    @(negedge clk); req_v_i = 2'b01; #1;
    n_checks++; if (req_yumi_o !== 2'b01) $display("FAIL ar_cnt0_second got %b want 01", req_yumi_o); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (v_o !== 1'b0) $display("FAIL ar_cnt0_full_v_o got %0b want 0", v_o); else n_pass++;
    req_v_i = 2'b10;
    for (int r = 0; r < 2; r++) begin
      #1;
      n_checks++; if (req_yumi_o !== 2'b10) $display("FAIL ar_cnt1_accept[%0d] got %b want 10", r, req_yumi_o); else n_pass++;
      @(negedge clk);
    end
    #1;
    n_checks++; if (v_o !== 1'b0) $display("FAIL ar_cnt1_full_v_o got %0b want 0", v_o); else n_pass++;
    req_v_i = '0; yumi_i = 1'b0;
  endtask

  task automatic test_single;
    @(negedge clk); s_req_v_i = 1'b1; s_yumi_i = 1'b1; #1;
    n_checks++; if (s_v_o !== 1'b1) $display("FAIL single_v_o got %0b want 1", s_v_o); else n_pass++;
    n_checks++; if (s_cache_pkt_o !== es) $display("FAIL single_pkt got %h want %h", s_cache_pkt_o, es); else n_pass++;
    n_checks++; if (s_req_yumi_o !== 1'b1) $display("FAIL single_req_yumi1 got %0b want 1", s_req_yumi_o); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (s_req_yumi_o !== 1'b1) $display("FAIL single_req_yumi2 got %0b want 1", s_req_yumi_o); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (s_v_o !== 1'b0) $display("FAIL single_limit_v_o got %0b want 0", s_v_o); else n_pass++;
    s_v_i = 1'b1; s_id_i = {1'b0, 17'h7}; s_data_i = 32'hCAFE_0007; s_req_yumi_i = 1'b1; #1;
    n_checks++; if (s_req_v_o !== 1'b1) $display("FAIL single_rsp_v got %0b want 1", s_req_v_o); else n_pass++;
    n_checks++; if (s_req_id_o !== 17'h7) $display("FAIL single_rsp_id got %h want 7", s_req_id_o); else n_pass++;
    n_checks++; if (s_yumi_o !== 1'b1) $display("FAIL single_rsp_yumi got %0b want 1", s_yumi_o); else n_pass++;
    @(negedge clk); s_v_i = 1'b0; s_req_yumi_i = 1'b0; #1;
    n_checks++; if (s_v_o !== 1'b1) $display("FAIL single_reenable_v_o got %0b want 1", s_v_o); else n_pass++;
    @(negedge clk); s_req_v_i = 1'b0; s_yumi_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    pkt0 = make_pkt(6'h02, 28'h0000100, 32'h0000_0000, 4'hF, 17'h00011);
    pkt1 = make_pkt(6'h0A, 28'h0000200, 32'hDEAD_BEEF, 4'h3, 17'h00022);
    spkt = make_pkt(6'h10, 28'h0ABCDEF, 32'h0000_0000, 4'h0, 17'h1FFFF);
    e0   = make_cpkt(6'h02, 28'h0000100, 32'h0000_0000, 4'hF, 1'b0, 17'h00011);
    e1   = make_cpkt(6'h0A, 28'h0000200, 32'hDEAD_BEEF, 4'h3, 1'b1, 17'h00022);
    es   = make_cpkt(6'h10, 28'h0ABCDEF, 32'h0000_0000, 4'h0, 1'b0, 17'h1FFFF);
    req_pkt_i = {pkt1, pkt0};
    s_req_pkt_i = spkt; s_req_v_i = 1'b0; s_yumi_i = 1'b0; s_v_i = 1'b0;
    s_id_i = '0; s_data_i = '0; s_req_yumi_i = 1'b0;

    test_reset();
    test_round_robin();
    test_limit_block();
    test_response_routing();
    test_drain();
    test_lock();
    test_same_cycle();
    test_async_reset();
    test_single();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
